// File: rtl/updown_counter_mod.sv
// Parametrised up/down event counter with programmable terminal value,
// wrap or saturate behaviour, synchronous clear and load, a combinational
// cascade carry and a sticky overflow flag.
//
// Per-cycle priority: rst_n low > clr > load > enable > hold.
// Cascading: feed this stage's carry_out into the next stage's enable.
// carry_out is high exactly when this stage is about to take its
// terminal-count step, which is the step that moves the next stage.
module updown_counter_mod #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_VAL  = 2**WIDTH - 1,
    parameter bit          SAT_MODE = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enable,
    input  logic             up_dn,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             carry_out,
    output logic             wrap_pulse,
    output logic             ovf,
    output logic             load_err
);

    // Terminal value at counter width; all compares against it are full
    // width, so MAX_VAL = 2**WIDTH-1 behaves like natural rollover.
    localparam logic [WIDTH-1:0] MAX_V = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ZERO  = '0;
    localparam logic [WIDTH-1:0] ONE   = {{(WIDTH-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic             load_err_q, load_err_d;

    logic at_max;
    logic at_zero;
    logic term_step;
    logic load_over;
    logic [WIDTH-1:0] step_val;

    // Limit detection and the terminal-step condition shared by the
    // next-state logic and the cascade carry.
    always_comb begin
        at_max    = (count_q == MAX_V);
        at_zero   = (count_q == ZERO);
        term_step = enable & ((up_dn & at_max) | (~up_dn & at_zero));
        load_over = (data_in > MAX_V);
    end

    // Value the counter moves to on an enabled step.
    always_comb begin
        step_val = count_q;
        if (up_dn) begin
            if (at_max) begin
                step_val = SAT_MODE ? MAX_V : ZERO;
            end else begin
                step_val = count_q + ONE;
            end
        end else begin
            if (at_zero) begin
                step_val = SAT_MODE ? ZERO : MAX_V;
            end else begin
                step_val = count_q - ONE;
            end
        end
    end

    // Next-state selection in priority order clr > load > enable > hold.
    // Reset is applied in the register block.
    always_comb begin
        count_d    = count_q;
        wrap_d     = 1'b0;
        load_err_d = 1'b0;
        ovf_d      = ovf_q & ~ovf_clr;
        if (clr) begin
            count_d = ZERO;
        end else if (load) begin
            if (load_over) begin
                count_d    = MAX_V;
                load_err_d = 1'b1;
            end else begin
                count_d = data_in;
            end
        end else if (enable) begin
            count_d = step_val;
            if (term_step) begin
                wrap_d = 1'b1;
                // A wrap/saturation event beats a simultaneous ovf_clr.
                ovf_d  = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset; ovf_clr is
    // irrelevant while in reset because everything is zeroed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q    <= ZERO;
            wrap_q     <= 1'b0;
            ovf_q      <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            wrap_q     <= wrap_d;
            ovf_q      <= ovf_d;
            load_err_q <= load_err_d;
        end
    end

    // Output mapping; carry_out is suppressed whenever this cycle's step
    // will not actually happen (reset, clear or load).
    always_comb begin
        count      = count_q;
        wrap_pulse = wrap_q;
        ovf        = ovf_q;
        load_err   = load_err_q;
        carry_out  = term_step & rst_n & ~clr & ~load;
    end

endmodule

// File: tb/tb_updown_counter_mod.sv
// Bench for updown_counter_mod: a vector table on a wrap-mode instance,
// a hand sequence on a saturate-mode instance and a two-stage cascade.
module tb_updown_counter_mod;

    logic clk;
    int   pass_cnt;
    int   total_cnt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wrap-mode instance, WIDTH=8, MAX_VAL=200
    logic       w_rst_n, w_clr, w_load, w_enable, w_up_dn, w_ovf_clr;
    logic [7:0] w_data_in, w_count;
    logic       w_carry, w_wrap, w_ovf, w_lerr;

    updown_counter_mod #(.WIDTH(8), .MAX_VAL(200), .SAT_MODE(1'b0)) dut_wrap (
        .clk(clk), .rst_n(w_rst_n), .clr(w_clr), .load(w_load),
        .data_in(w_data_in), .enable(w_enable), .up_dn(w_up_dn),
        .ovf_clr(w_ovf_clr), .count(w_count), .carry_out(w_carry),
        .wrap_pulse(w_wrap), .ovf(w_ovf), .load_err(w_lerr)
    );

    // Saturate-mode instance, WIDTH=8, MAX_VAL=200
    logic       s_rst_n, s_clr, s_load, s_enable, s_up_dn, s_ovf_clr;
    logic [7:0] s_data_in, s_count;
    logic       s_carry, s_wrap, s_ovf, s_lerr;

    updown_counter_mod #(.WIDTH(8), .MAX_VAL(200), .SAT_MODE(1'b1)) dut_sat (
        .clk(clk), .rst_n(s_rst_n), .clr(s_clr), .load(s_load),
        .data_in(s_data_in), .enable(s_enable), .up_dn(s_up_dn),
        .ovf_clr(s_ovf_clr), .count(s_count), .carry_out(s_carry),
        .wrap_pulse(s_wrap), .ovf(s_ovf), .load_err(s_lerr)
    );

    // Two-stage decade cascade, WIDTH=4, MAX_VAL=9
    logic       c_rst_n, c_en;
    logic [3:0] c1_count, c2_count;
    logic       c1_carry, c1_wrap, c1_ovf, c1_lerr;
    logic       c2_carry, c2_wrap, c2_ovf, c2_lerr;

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1'b0)) dut_c1 (
        .clk(clk), .rst_n(c_rst_n), .clr(1'b0), .load(1'b0),
        .data_in(4'd0), .enable(c_en), .up_dn(1'b1), .ovf_clr(1'b0),
        .count(c1_count), .carry_out(c1_carry), .wrap_pulse(c1_wrap),
        .ovf(c1_ovf), .load_err(c1_lerr)
    );

    updown_counter_mod #(.WIDTH(4), .MAX_VAL(9), .SAT_MODE(1'b0)) dut_c2 (
        .clk(clk), .rst_n(c_rst_n), .clr(1'b0), .load(1'b0),
        .data_in(4'd0), .enable(c1_carry), .up_dn(1'b1), .ovf_clr(1'b0),
        .count(c2_count), .carry_out(c2_carry), .wrap_pulse(c2_wrap),
        .ovf(c2_ovf), .load_err(c2_lerr)
    );

    typedef struct {
        logic       rst_n;
        logic       clr;
        logic       load;
        logic [7:0] data_in;
        logic       enable;
        logic       up_dn;
        logic       ovf_clr;
        logic       exp_carry;   // before the edge
        logic [7:0] exp_count;   // after the edge
        logic       exp_wrap;
        logic       exp_ovf;
        logic       exp_lerr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic rst_n, input logic clr, input logic load,
                                input logic [7:0] din, input logic en, input logic up,
                                input logic oc, input logic e_carry, input logic [7:0] e_cnt,
                                input logic e_wrap, input logic e_ovf, input logic e_lerr);
        vec_t v;
        v.rst_n = rst_n; v.clr = clr; v.load = load; v.data_in = din;
        v.enable = en; v.up_dn = up; v.ovf_clr = oc;
        v.exp_carry = e_carry; v.exp_count = e_cnt; v.exp_wrap = e_wrap;
        v.exp_ovf = e_ovf; v.exp_lerr = e_lerr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One saturate-instance step: drive, check carry pre-edge, then outputs post-edge
    task automatic sat_step(input string name, input logic load, input logic [7:0] din,
                            input logic en, input logic up, input logic e_carry,
                            input logic [7:0] e_cnt, input logic e_wrap, input logic e_ovf);
        s_load = load; s_data_in = din; s_enable = en; s_up_dn = up;
        #1;
        check({name, " carry"}, {31'd0, s_carry}, {31'd0, e_carry});
        @(posedge clk); #1;
        check({name, " count"}, {24'd0, s_count}, {24'd0, e_cnt});
        check({name, " wrap"}, {31'd0, s_wrap}, {31'd0, e_wrap});
        check({name, " ovf"}, {31'd0, s_ovf}, {31'd0, e_ovf});
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        w_rst_n = 1'b0; w_clr = 1'b0; w_load = 1'b0; w_data_in = 8'd0;
        w_enable = 1'b0; w_up_dn = 1'b1; w_ovf_clr = 1'b0;
        s_rst_n = 1'b0; s_clr = 1'b0; s_load = 1'b0; s_data_in = 8'd0;
        s_enable = 1'b0; s_up_dn = 1'b1; s_ovf_clr = 1'b0;
        c_rst_n = 1'b0; c_en = 1'b0;

        //            rst clr ld din en up oc | carry cnt wrap ovf lerr
        vecs.push_back(mk(0, 0, 0,   0, 0, 1, 0,  0,   0, 0, 0, 0)); // reset state
        vecs.push_back(mk(1, 0, 1, 150, 0, 1, 0,  0, 150, 0, 0, 0)); // load 150
        vecs.push_back(mk(0, 0, 0,   0, 1, 1, 0,  0,   0, 0, 0, 0)); // reset mid-count
        vecs.push_back(mk(1, 0, 1, 198, 0, 1, 0,  0, 198, 0, 0, 0)); // load 198
        vecs.push_back(mk(1, 0, 0,   0, 1, 1, 0,  0, 199, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 1, 1, 0,  0, 200, 0, 0, 0));
        vecs.push_back(mk(1, 0, 0,   0, 1, 1, 0,  1,   0, 1, 1, 0)); // wrap up
        vecs.push_back(mk(1, 0, 0,   0, 1, 1, 0,  0,   1, 0, 1, 0)); // ovf sticky
        vecs.push_back(mk(1, 0, 0,   0, 0, 1, 1,  0,   1, 0, 0, 0)); // ovf_clr
        vecs.push_back(mk(1, 0, 1, 250, 1, 1, 0,  0, 200, 0, 0, 1)); // clamp, load>enable
        vecs.push_back(mk(1, 0, 0,   0, 0, 1, 0,  0, 200, 0, 0, 0)); // lerr one cycle
        vecs.push_back(mk(1, 1, 1,   5, 0, 1, 0,  0,   0, 0, 0, 0)); // clr beats load
        vecs.push_back(mk(1, 0, 0,   0, 1, 0, 0,  1, 200, 1, 1, 0)); // wrap down
        vecs.push_back(mk(1, 0, 0,   0, 1, 1, 1,  1,   0, 1, 1, 0)); // set beats ovf_clr
        vecs.push_back(mk(1, 0, 0,   0, 0, 1, 1,  0,   0, 0, 0, 0)); // clr with no wrap
        vecs.push_back(mk(1, 0, 1, 200, 1, 1, 0,  0, 200, 0, 0, 0)); // load MAX, no err
        vecs.push_back(mk(1, 1, 0,   0, 1, 1, 0,  0,   0, 0, 0, 0)); // clr kills carry
        vecs.push_back(mk(1, 0, 0,   0, 1, 0, 0,  1, 200, 1, 1, 0)); // direction toggle
        vecs.push_back(mk(1, 0, 0,   0, 1, 0, 0,  0, 199, 0, 1, 0));
        vecs.push_back(mk(1, 1, 0,   0, 0, 1, 0,  0,   0, 0, 1, 0)); // clr keeps ovf
        vecs.push_back(mk(0, 0, 0,   0, 1, 1, 1,  0,   0, 0, 0, 0)); // reset clears ovf

        @(posedge clk); #1;
        foreach (vecs[i]) begin
            w_rst_n = vecs[i].rst_n; w_clr = vecs[i].clr; w_load = vecs[i].load;
            w_data_in = vecs[i].data_in; w_enable = vecs[i].enable;
            w_up_dn = vecs[i].up_dn; w_ovf_clr = vecs[i].ovf_clr;
            #1;
            check($sformatf("vec%0d carry", i), {31'd0, w_carry}, {31'd0, vecs[i].exp_carry});
            @(posedge clk); #1;
            check($sformatf("vec%0d count", i), {24'd0, w_count}, {24'd0, vecs[i].exp_count});
            check($sformatf("vec%0d wrap", i), {31'd0, w_wrap}, {31'd0, vecs[i].exp_wrap});
            check($sformatf("vec%0d ovf", i), {31'd0, w_ovf}, {31'd0, vecs[i].exp_ovf});
            check($sformatf("vec%0d lerr", i), {31'd0, w_lerr}, {31'd0, vecs[i].exp_lerr});
        end

        // Saturate mode: down into 0 and hold, then up into MAX and hold
        s_rst_n = 1'b0;
        @(posedge clk); #1;
        s_rst_n = 1'b1;
        sat_step("sat load2", 1, 8'd2,   0, 0, 0, 8'd2,   0, 0);
        sat_step("sat dn1",   0, 8'd0,   1, 0, 0, 8'd1,   0, 0);
        sat_step("sat dn2",   0, 8'd0,   1, 0, 0, 8'd0,   0, 0);
        sat_step("sat dn3",   0, 8'd0,   1, 0, 1, 8'd0,   1, 1);
        sat_step("sat dn4",   0, 8'd0,   1, 0, 1, 8'd0,   1, 1);
        sat_step("sat hold",  0, 8'd0,   0, 0, 0, 8'd0,   0, 1);
        sat_step("sat ld199", 1, 8'd199, 0, 1, 0, 8'd199, 0, 1);
        sat_step("sat up1",   0, 8'd0,   1, 1, 0, 8'd200, 0, 1);
        sat_step("sat up2",   0, 8'd0,   1, 1, 1, 8'd200, 1, 1);
        sat_step("sat up3",   0, 8'd0,   1, 1, 1, 8'd200, 1, 1);
        sat_step("sat dn",    0, 8'd0,   1, 0, 0, 8'd199, 0, 1);

        // Decade cascade: 25 enabled cycles from 0 -> stage1=5, stage2=2
        c_rst_n = 1'b0;
        @(posedge clk); #1;
        check("casc reset s1", {28'd0, c1_count}, 32'd0);
        check("casc reset s2", {28'd0, c2_count}, 32'd0);
        c_rst_n = 1'b1;
        c_en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
        end
        c_en = 1'b0;
        check("casc s1", {28'd0, c1_count}, 32'd5);
        check("casc s2", {28'd0, c2_count}, 32'd2);
        check("casc s2 ovf", {31'd0, c2_ovf}, 32'd0);
        check("casc s1 ovf", {31'd0, c1_ovf}, 32'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/updown_counter_mod.md
Name: updown_counter_mod

Overview:
- Parametrised successor to the team's 8-bit load/enable counter.
- Adds configurable width, programmable modulus, up/down direction, and wrap or saturate mode.
- Adds synchronous clear, a cascade carry output, and a sticky overflow flag.
- Used as a general event/timer counter inside interface-based testbench DUTs and datapath blocks; instances cascade through en/carry_out.

Parameters:
- WIDTH, 8: counter width in bits (>=2).
- MAX_VAL, 2**WIDTH-1: terminal value. Count range is 0..MAX_VAL. Must be >=1 and <=2**WIDTH-1.
- SAT_MODE, 0: 0 = wrap (modulo MAX_VAL+1); 1 = saturate at the limits.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: reset, synchronous, active-low.
- clr, input, 1: synchronous clear of count to 0.
- load, input, 1: load data_in.
- data_in, input, WIDTH: load value.
- enable, input, 1: count-enable.
- up_dn, input, 1: 1 = increment, 0 = decrement.
- ovf_clr, input, 1: clears the sticky ovf flag.
- count, output, WIDTH: current count, registered.
- carry_out, output, 1: combinational cascade carry/borrow.
- wrap_pulse, output, 1: registered one-cycle pulse on wrap or saturation hit.
- ovf, output, 1: sticky overflow/underflow flag.
- load_err, output, 1: registered one-cycle pulse when a load value exceeds MAX_VAL.

Behaviour:
- All state updates on rising clk; no asynchronous paths.
- Priority per cycle: rst_n low > clr > load > enable > hold.

Reset (rst_n=0 at a clk edge):
- count=0, wrap_pulse=0, ovf=0, load_err=0.
- Reset mid-count discards the in-flight increment.
- ovf_clr has no effect while in reset.

Clear:
- clr=1 sets count=0 and wrap_pulse=0.
- ovf is untouched.

Load:
- If data_in <= MAX_VAL: count <= data_in.
- If data_in > MAX_VAL: count <= MAX_VAL and load_err=1 for one cycle.
- Load never sets wrap_pulse or ovf. Load wins over enable in the same cycle.

Count (enable=1, no clr, no load):
- Up, count<MAX_VAL: count+1.
- Up, count==MAX_VAL:
  - SAT_MODE=0: count becomes 0.
  - SAT_MODE=1: count holds at MAX_VAL.
  - Either mode: wrap_pulse=1 next cycle, ovf set.
- Down, count>0: count-1.
- Down, count==0:
  - SAT_MODE=0: count becomes MAX_VAL.
  - SAT_MODE=1: count holds at 0.
  - Either mode: wrap_pulse=1 next cycle, ovf set.
- Arithmetic is WIDTH bits. The MAX_VAL compare is full-width, so for MAX_VAL=2**WIDTH-1 natural rollover behaves identically.

carry_out:
- carry_out = enable & ((up_dn & count==MAX_VAL) | (~up_dn & count==0)).
- Forced 0 when clr, load or ~rst_n is asserted.
- Valid in the same cycle as the terminal count; drives the next stage's enable.

wrap_pulse:
- High exactly in the cycle after the terminal-count step, otherwise 0.
- In saturate mode it pulses on every enabled cycle spent at the limit.

ovf:
- Set by any wrap or saturation event.
- Cleared by ovf_clr=1.
- Set wins if a set and ovf_clr occur in the same cycle.

Direction change:
- up_dn may toggle on any cycle and takes effect on that cycle's step; no dead cycle.

Enable low:
- count holds; wrap_pulse=0.
- load_err is 0 on every cycle without an offending load.

Test Plan:
- Reset: WIDTH=8, MAX_VAL=200. Load 150, then assert rst_n=0 for one edge with enable=1 → count=0, ovf=0, wrap_pulse=0 on the following cycle.
- Wrap up: SAT_MODE=0. Load 198, up_dn=1, enable=1 for 4 cycles → count 199, 200, 0, 1. carry_out=1 while count=200; wrap_pulse=1 in the cycle count=0; ovf=1 thereafter until ovf_clr.
- Saturate down: SAT_MODE=1. Load 2, up_dn=0, enable for 4 cycles → count 1, 0, 0, 0. wrap_pulse high in the last two cycles; ovf=1.
- Load priority and clamp: load=1, enable=1, data_in=250 → count=200, load_err=1 for one cycle, wrap_pulse=0. Then load 5 with clr=1 → count=0.
- Cascade: two instances with WIDTH=4, MAX_VAL=9, stage-2 enable = stage-1 carry_out. Run 25 enabled up cycles from 0 → stage1=5, stage2=2.
- Sticky ovf race: cause a wrap in the same cycle that ovf_clr=1 → ovf=1. Next cycle ovf_clr=1 with no wrap → ovf=0.
